// File: rtl/relu_pkg.sv
// Shared types and constants for the ReLU layer driver: FSM state encoding and data-width defaults.
package relu_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int SIGN_BIT       = DATA_W_DEFAULT - 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        ISSUE   = 3'd2,
        CAPTURE = 3'd3,
        FINISH  = 3'd4
    } state_t;

endpackage

// File: rtl/relu_layer_driver.sv
// Sequences one layer's results through an external ReLU unit: read, issue, capture, write back.
// Optional macro RELU_LAYER_DRIVER_CLAMP_COUNT_EN adds clamp_count (negative inputs seen this run).
//
// state   | meaning
// IDLE    | waiting for start, all outputs low
// READ    | src_rd_en with src_addr = idx
// ISSUE   | src_data presented to ReLU with relu_valid
// CAPTURE | relu_out written to dst at idx; advance or finish
// FINISH  | one-cycle done pulse
module relu_layer_driver
    import relu_pkg::*;
#(
    parameter int NUM_NEURONS = 10,
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int ADDR_W      = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    output logic [DATA_W-1:0] relu_in,
    output logic              relu_valid,
    input  logic [DATA_W-1:0] relu_out,
    input  logic              relu_done,
    output logic              dst_wr_en,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [DATA_W-1:0] dst_data
`ifdef RELU_LAYER_DRIVER_CLAMP_COUNT_EN
    ,
    output logic [ADDR_W:0]   clamp_count
`endif
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;

    // relu_done is a sticky level from the unit and carries no per-item information.
    logic relu_done_unused;
    assign relu_done_unused = relu_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        busy       = 1'b0;
        done       = 1'b0;
        src_rd_en  = 1'b0;
        src_addr   = '0;
        relu_in    = '0;
        relu_valid = 1'b0;
        dst_wr_en  = 1'b0;
        dst_addr   = '0;
        dst_data   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = READ;
                    idx_nxt   = '0;
                end
            end
            READ: begin
                busy      = 1'b1;
                src_rd_en = 1'b1;
                src_addr  = idx;
                state_nxt = ISSUE;
            end
            ISSUE: begin
                busy       = 1'b1;
                relu_valid = 1'b1;
                relu_in    = src_data;
                state_nxt  = CAPTURE;
            end
            CAPTURE: begin
                busy      = 1'b1;
                dst_wr_en = 1'b1;
                dst_addr  = idx;
                dst_data  = relu_out;
                if (idx == LAST_IDX) begin
                    state_nxt = FINISH;
                end else begin
                    idx_nxt   = idx + ADDR_W'(1);
                    state_nxt = READ;
                end
            end
            FINISH: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef RELU_LAYER_DRIVER_CLAMP_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            clamp_count <= '0;
        end else if (state == IDLE && start) begin
            clamp_count <= '0;
        end else if (state == ISSUE && src_data[DATA_W-1]) begin
            clamp_count <= clamp_count + (ADDR_W + 1)'(1);
        end
    end
`endif

endmodule

// File: tb/tb_relu_layer_driver.sv
// Self-checking bench for relu_layer_driver: a 4-neuron and a 1-neuron instance with buffer and ReLU models.
module tb_relu_layer_driver;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int N4 = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic start1 = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // 4-neuron instance
    logic          busy, done, src_rd_en, relu_valid, dst_wr_en;
    logic [AW-1:0] src_addr, dst_addr;
    logic [DW-1:0] src_data = '0, relu_in, relu_out = '0, dst_data;
    logic          relu_done = 1'b0;
    logic [DW-1:0] mem [16];

    // 1-neuron instance
    logic          busy1, done1, src_rd_en1, relu_valid1, dst_wr_en1;
    logic [AW-1:0] src_addr1, dst_addr1;
    logic [DW-1:0] src_data1 = '0, relu_in1, relu_out1 = '0, dst_data1;
    logic          relu_done1 = 1'b0;
    logic [DW-1:0] mem1;

`ifdef RELU_LAYER_DRIVER_CLAMP_COUNT_EN
    logic [AW:0] clamp_count, clamp_count1;
`endif

    relu_layer_driver #(.NUM_NEURONS(N4), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .src_rd_en(src_rd_en), .src_addr(src_addr), .src_data(src_data),
        .relu_in(relu_in), .relu_valid(relu_valid), .relu_out(relu_out), .relu_done(relu_done),
        .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .dst_data(dst_data)
`ifdef RELU_LAYER_DRIVER_CLAMP_COUNT_EN
        , .clamp_count(clamp_count)
`endif
    );

    relu_layer_driver #(.NUM_NEURONS(1), .DATA_W(DW), .ADDR_W(AW)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .src_rd_en(src_rd_en1), .src_addr(src_addr1), .src_data(src_data1),
        .relu_in(relu_in1), .relu_valid(relu_valid1), .relu_out(relu_out1), .relu_done(relu_done1),
        .dst_wr_en(dst_wr_en1), .dst_addr(dst_addr1), .dst_data(dst_data1)
`ifdef RELU_LAYER_DRIVER_CLAMP_COUNT_EN
        , .clamp_count(clamp_count1)
`endif
    );

    // Result buffers (1-cycle read latency) and ReLU units (registered output, sticky done).
    always @(posedge clock) begin
        if (src_rd_en) src_data <= mem[src_addr];
        if (relu_valid) begin
            relu_out  <= ($signed(relu_in) < 0) ? '0 : relu_in;
            relu_done <= 1'b1;
        end
        if (src_rd_en1) src_data1 <= mem1;
        if (relu_valid1) begin
            relu_out1  <= ($signed(relu_in1) < 0) ? '0 : relu_in1;
            relu_done1 <= 1'b1;
        end
    end

    function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] x);
        int signed v;
        v = int'(x);
        return (v > 0) ? x : '0;
    endfunction

    // Per-run observation record, cycle numbers relative to the start cycle S.
    int            rd_q[$], val_q[$], wr_q[$], done_q[$];
    logic [AW-1:0] rd_addr_q[$], wr_addr_q[$];
    logic [DW-1:0] issue_q[$], wr_data_q[$];
    int            busy_first, busy_last, busy_cnt, stray;
    int            clamp_at_done;

    task automatic run4(input int cycles, input int pa, input int pb, input int pc);
        rd_q.delete(); val_q.delete(); wr_q.delete(); done_q.delete();
        rd_addr_q.delete(); wr_addr_q.delete(); issue_q.delete(); wr_data_q.delete();
        busy_first = -1; busy_last = -1; busy_cnt = 0; stray = 0; clamp_at_done = -1;
        @(negedge clock);
        start = 1'b1;
        for (int k = 1; k <= cycles; k++) begin
            @(negedge clock);
            start = (k == pa || k == pb || k == pc);
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = k;
                busy_last = k;
            end
            if (done) begin
                done_q.push_back(k);
`ifdef RELU_LAYER_DRIVER_CLAMP_COUNT_EN
                clamp_at_done = int'(clamp_count);
`endif
            end
            if (src_rd_en) begin rd_q.push_back(k); rd_addr_q.push_back(src_addr); end
            if (relu_valid) begin val_q.push_back(k); issue_q.push_back(relu_in); end
            if (dst_wr_en) begin wr_q.push_back(k); wr_addr_q.push_back(dst_addr); wr_data_q.push_back(dst_data); end
            if (!src_rd_en && src_addr != '0) stray++;
            if (!relu_valid && relu_in != '0) stray++;
            if (!dst_wr_en && (dst_addr != '0 || dst_data != '0)) stray++;
            if (!busy && (done || src_rd_en || relu_valid || dst_wr_en)) stray++;
            if (done && (src_rd_en || relu_valid || dst_wr_en)) stray++;
        end
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL wait_idle timeout busy=%0b required=0", busy);
        end
    endtask

    task automatic check_pass(input string tag);
        int negs;
        negs = 0;
        checks++;
        if (wr_q.size() != N4) begin
            failures++;
            $display("FAIL %s write_count got=%0d required=%0d", tag, wr_q.size(), N4);
        end
        for (int i = 0; i < N4 && i < wr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== relu_ref(mem[i])) begin
                failures++;
                $display("FAIL %s write[%0d] got addr=%0d data=%h required addr=%0d data=%h",
                         tag, i, wr_addr_q[i], wr_data_q[i], i, relu_ref(mem[i]));
            end
            if (mem[i][DW-1]) negs++;
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != 1 + 3 * N4) begin
            failures++;
            $display("FAIL %s done_timing got count=%0d first=%0d required count=1 at=%0d",
                     tag, done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, 1 + 3 * N4);
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL %s idle_outputs_nonzero got=%0d required=0", tag, stray);
        end
`ifdef RELU_LAYER_DRIVER_CLAMP_COUNT_EN
        checks++;
        if (clamp_at_done != negs) begin
            failures++;
            $display("FAIL %s clamp_count got=%0d required=%0d", tag, clamp_at_done, negs);
        end
`else
        if (negs < 0) $display("unexpected");
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({busy, done, src_rd_en, relu_valid, dst_wr_en, src_addr, dst_addr, relu_in, dst_data} !== '0 ||
            {busy1, done1, src_rd_en1, relu_valid1, dst_wr_en1, src_addr1, dst_addr1, relu_in1, dst_data1} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%0b rd=%0b val=%0b wr=%0b required all 0", busy, src_rd_en, relu_valid, dst_wr_en);
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL idle_without_start got busy=%0b busy1=%0b required 0", busy, busy1);
        end
    endtask

    task automatic test_basic();
        mem[0] = 32'h0000_0005; mem[1] = 32'hFFFF_FFFE; mem[2] = 32'h7FFF_FFFF; mem[3] = 32'h8000_0000;
        run4(16, -1, -1, -1);
        check_pass("basic");
        checks++;
        if (wr_data_q.size() == 4 && (wr_data_q[0] !== 32'd5 || wr_data_q[1] !== 32'd0 ||
            wr_data_q[2] !== 32'h7FFF_FFFF || wr_data_q[3] !== 32'd0)) begin
            failures++;
            $display("FAIL basic_fixed_data got %h %h %h %h required 5 0 7fffffff 0",
                     wr_data_q[0], wr_data_q[1], wr_data_q[2], wr_data_q[3]);
        end
        checks++;
        if (busy_first != 1 || busy_last != 13 || busy_cnt != 13) begin
            failures++;
            $display("FAIL basic_busy got first=%0d last=%0d cnt=%0d required 1 13 13", busy_first, busy_last, busy_cnt);
        end
`ifdef RELU_LAYER_DRIVER_CLAMP_COUNT_EN
        checks++;
        if (clamp_at_done != 2) begin
            failures++;
            $display("FAIL basic_clamp got=%0d required=2", clamp_at_done);
        end
`endif
    endtask

    task automatic test_handshake();
        for (int i = 0; i < N4; i++) mem[i] = $urandom;
        run4(16, -1, -1, -1);
        checks++;
        if (rd_q.size() != N4 || val_q.size() != N4 || wr_q.size() != N4) begin
            failures++;
            $display("FAIL handshake_counts got rd=%0d val=%0d wr=%0d required 4 each", rd_q.size(), val_q.size(), wr_q.size());
        end
        for (int i = 0; i < N4 && i < rd_q.size() && i < val_q.size() && i < wr_q.size(); i++) begin
            checks++;
            if (rd_q[i] != 1 + 3 * i || val_q[i] != rd_q[i] + 1 || wr_q[i] != val_q[i] + 1 ||
                rd_addr_q[i] !== AW'(i) || issue_q[i] !== mem[i]) begin
                failures++;
                $display("FAIL handshake[%0d] got rd=%0d val=%0d wr=%0d addr=%0d in=%h required rd=%0d addr=%0d in=%h",
                         i, rd_q[i], val_q[i], wr_q[i], rd_addr_q[i], issue_q[i], 1 + 3 * i, i, mem[i]);
            end
        end
        check_pass("handshake");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N4; i++) begin
                case ($urandom_range(0, 4))
                    0: mem[i] = 32'h0000_0000;
                    1: mem[i] = 32'h8000_0000;
                    2: mem[i] = 32'hFFFF_FFFF;
                    default: mem[i] = $urandom;
                endcase
            end
            run4(15, -1, -1, -1);
            check_pass("random");
        end
        for (int i = 0; i < N4; i++) mem[i] = $urandom_range(1, 32'h7FFF_FFFF);
        run4(15, -1, -1, -1);
        check_pass("all_positive");
`ifdef RELU_LAYER_DRIVER_CLAMP_COUNT_EN
        checks++;
        if (clamp_count !== '0) begin
            failures++;
            $display("FAIL clamp_held got=%0d required=0", clamp_count);
        end
`endif
    endtask

    task automatic test_start_while_busy();
        for (int i = 0; i < N4; i++) mem[i] = $urandom;
        run4(16, 5, 13, 14);
        checks++;
        if (done_q.size() != 1 || done_q[0] != 13 || wr_q.size() != N4) begin
            failures++;
            $display("FAIL busy_start_ignored got done=%0d writes=%0d required done=1 writes=4", done_q.size(), wr_q.size());
        end
        checks++;
        if (rd_q.size() != N4 + 1 || rd_q[N4] != 15) begin
            failures++;
            $display("FAIL restart_accept got reads=%0d required 5 with last at 15", rd_q.size());
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_run();
        int writes;
        for (int i = 0; i < N4; i++) mem[i] = $urandom;
        writes = 0;
        @(negedge clock);
        start = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (dst_wr_en) writes++;
        end
        checks++;
        if (relu_valid !== 1'b1 || writes != 3) begin
            failures++;
            $display("FAIL midrun_position got relu_valid=%0b writes=%0d required 1 3", relu_valid, writes);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({busy, done, src_rd_en, relu_valid, dst_wr_en, src_addr, dst_addr, relu_in, dst_data} !== '0) begin
            failures++;
            $display("FAIL midrun_reset got busy=%0b val=%0b wr=%0b required all 0", busy, relu_valid, dst_wr_en);
        end
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < N4; i++) mem[i] = $urandom;
        run4(16, -1, -1, -1);
        check_pass("after_reset");
    endtask

    task automatic test_single();
        int wr_n, done_at;
        logic [DW-1:0] got;
        for (int r = 0; r < 2; r++) begin
            mem1 = (r == 0) ? 32'hFFFF_FFFF : $urandom_range(1, 32'h7FFF_FFFF);
            wr_n = 0; done_at = -1; got = 'x;
            @(negedge clock);
            start1 = 1'b1;
            for (int k = 1; k <= 7; k++) begin
                @(negedge clock);
                start1 = 1'b0;
                if (dst_wr_en1) begin
                    wr_n++;
                    got = dst_data1;
                    checks++;
                    if (k != 3 || dst_addr1 !== '0) begin
                        failures++;
                        $display("FAIL single_write_pos got k=%0d addr=%0d required k=3 addr=0", k, dst_addr1);
                    end
                end
                if (done1) begin
                    done_at = k;
`ifdef RELU_LAYER_DRIVER_CLAMP_COUNT_EN
                    checks++;
                    if (int'(clamp_count1) != int'(mem1[DW-1])) begin
                        failures++;
                        $display("FAIL single_clamp got=%0d required=%0d", clamp_count1, mem1[DW-1]);
                    end
`endif
                end
            end
            checks++;
            if (wr_n != 1 || got !== relu_ref(mem1) || done_at != 4) begin
                failures++;
                $display("FAIL single got writes=%0d data=%h done=%0d required 1 %h 4", wr_n, got, done_at, relu_ref(mem1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_handshake();
        test_random();
        test_start_while_busy();
        test_reset_mid_run();
        test_single();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=expired required=finish");
        $fatal(1, "timeout");
    end
endmodule
